// File: rtl/ms_qspi_pkg.sv
// ---------------------------------------------------------------------------
// ms_qspi_pkg
// Shared definitions for the QSPI XIP flash reader and the cache controller
// that sits in front of it.
//   state_t        : transaction FSM states
//   CMD_QUAD_READ  : Quad I/O Fast Read opcode
//   *_SCK          : SCK cycles spent in each fixed-length protocol phase
//   max_int        : small helper for sizing counters from parameters
// ---------------------------------------------------------------------------
package ms_qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        GAP
    } state_t;

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;

    localparam int CMD_SCK   = 8;
    localparam int ADDR_SCK  = 6;
    localparam int MODE_SCK  = 2;
    localparam int DUMMY_SCK = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_qspi_xip_reader.sv
// ---------------------------------------------------------------------------
// ms_qspi_xip_reader
// Line fetcher behind the XIP cache. Each accepted request runs one Quad I/O
// Fast Read (0xEB) on the QSPI pins and returns the whole line in one word.
//
// Ports
//   HCLK, HRESETn : system clock, asynchronous active-low reset
//   req, addr     : fetch request and 24-bit flash byte address of the line
//   busy          : high from accept until the ce_n-high gap has elapsed
//   done, data    : one-cycle completion pulse and the little-endian line
//   sck, ce_n     : SPI clock (mode 0, HCLK/2) and chip enable (active low)
//   din           : SIO inputs sampled from the flash
//   dout, douten  : SIO drive values and enables (all enable bits equal)
//
// Handshake: req is looked at only while the FSM is IDLE (busy=0); the cycle
// it is seen high the request is accepted and addr is latched. While busy=1
// req is ignored and nothing is queued. done pulses for exactly one cycle
// and data is valid from that cycle until the next done.
//
// SCK timing: each SCK period is two HCLK cycles. The edge that drops sck
// also loads dout for the coming SCK period (and, in DATA, captures din);
// the next edge raises sck so the flash samples a stable dout.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ms_qspi_xip_reader
    import ms_qspi_pkg::*;
#(
    parameter int          LINE_BYTES     = 16,
    parameter int          CE_HIGH_CYCLES = 4,
    parameter logic [7:0]  MODE_BYTE      = 8'hFF
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    req,
    input  logic [23:0]             addr,
    output logic                    busy,
    output logic                    done,
    output logic [LINE_BYTES*8-1:0] data,
    output logic                    sck,
    output logic                    ce_n,
    input  logic [3:0]              din,
    output logic [3:0]              dout,
    output logic [3:0]              douten
);

    localparam int DATA_W   = LINE_BYTES * 8;
    localparam int DATA_SCK = 2 * LINE_BYTES;
    localparam int CNT_MAX  = max_int(CMD_SCK, DATA_SCK);
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_W    = (CE_HIGH_CYCLES > 1) ? $clog2(CE_HIGH_CYCLES) : 1;

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CE_HIGH_CYCLES - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Index of the final SCK period of each counted phase.
    function automatic logic [CNT_W-1:0] last_cnt(input state_t s);
        case (s)
            CMD:     return CNT_W'(CMD_SCK - 1);
            ADDR:    return CNT_W'(ADDR_SCK - 1);
            MODE:    return CNT_W'(MODE_SCK - 1);
            DUMMY:   return CNT_W'(DUMMY_SCK - 1);
            DATA:    return CNT_W'(DATA_SCK - 1);
            default: return '0;
        endcase
    endfunction

    function automatic state_t following(input state_t s);
        case (s)
            CMD:     return ADDR;
            ADDR:    return MODE;
            MODE:    return DUMMY;
            DUMMY:   return DATA;
            DATA:    return GAP;
            default: return IDLE;
        endcase
    endfunction

    // Value on SIO[3:0] during SCK period c of phase s. In CMD the upper
    // three lines stay high so WP#/HOLD# are never asserted.
    function automatic logic [3:0] sio_value(input state_t s,
                                             input logic [CNT_W-1:0] c,
                                             input logic [23:0] a);
        case (s)
            CMD:     return {3'b111, |(8'(CMD_QUAD_READ << c) & 8'h80)};
            ADDR:    return 4'(24'(a << {c, 2'b00}) >> 20);
            MODE:    return 4'(8'(MODE_BYTE << {c, 2'b00}) >> 4);
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] sio_oe(input state_t s);
        case (s)
            CMD, ADDR, MODE: return 4'b1111;
            default:         return 4'b0000;
        endcase
    endfunction

    // The shift register holds the first received byte at the top; the line
    // wants it in the lowest byte lane.
    function automatic logic [DATA_W-1:0] to_line(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            r[8*i +: 8] = s[DATA_W-1-8*i -: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [23:0]        addr_q, addr_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               sck_q, sck_d;
    logic               ce_n_q, ce_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         dout_q, dout_d;
    logic [3:0]         douten_q, douten_d;

    state_t             nxt_state;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [DATA_W-1:0]  shift_in;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            sck_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= 4'b0000;
            douten_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            sck_q    <= sck_d;
            ce_n_q   <= ce_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            douten_q <= douten_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        data_d    = data_q;
        sck_d     = sck_q;
        ce_n_d    = ce_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dout_d    = dout_q;
        douten_d  = douten_q;
        nxt_state = state_q;
        nxt_cnt   = cnt_q;
        shift_in  = {shift_q[DATA_W-5:0], din};

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = addr;
                    busy_d   = 1'b1;
                    ce_n_d   = 1'b0;
                    sck_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = CMD;
                    dout_d   = sio_value(CMD, '0, addr);
                    douten_d = sio_oe(CMD);
                end
            end

            CMD, ADDR, MODE, DUMMY, DATA: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // Falling edge of SCK: capture, advance, load next dout.
                    sck_d = 1'b0;
                    if (state_q == DATA) begin
                        shift_d = shift_in;
                    end
                    if (cnt_q == last_cnt(state_q)) begin
                        nxt_state = following(state_q);
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt   = cnt_q + 1'b1;
                    end
                    state_d  = nxt_state;
                    cnt_d    = nxt_cnt;
                    dout_d   = sio_value(nxt_state, nxt_cnt, addr_q);
                    douten_d = sio_oe(nxt_state);
                    if (nxt_state == GAP) begin
                        ce_n_d = 1'b1;
                        data_d = to_line(shift_in);
                        done_d = 1'b1;
                        gap_d  = '0;
                    end
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign data   = data_q;
    assign sck    = sck_q;
    assign ce_n   = ce_n_q;
    assign dout   = dout_q;
    assign douten = douten_q;

endmodule
